// File: rtl/target_pkg.sv
// -----------------------------------------------------------------------------
// target_pkg
// Shared constants and types for the target locator.
//   IMG_W_DEF / IMG_H_DEF / MIN_PIXELS_DEF : default frame geometry and threshold
//   XW / YW / CW                           : column, row and hit-count widths
//   DIVW                                   : width of sum_x, which is also the
//                                            width of both serial dividers
//   frame_state_t / div_state_t            : FSM encodings
//   result_t                               : one frame's reported result
// -----------------------------------------------------------------------------
package target_pkg;

    localparam int IMG_W_DEF      = 320;
    localparam int IMG_H_DEF      = 240;
    localparam int MIN_PIXELS_DEF = 64;

    localparam int XW   = $clog2(IMG_W_DEF);
    localparam int YW   = $clog2(IMG_H_DEF);
    localparam int CW   = $clog2(IMG_W_DEF * IMG_H_DEF + 1);
    localparam int DIVW = CW + XW;

    typedef enum logic {WAIT_SOP, ACCUM}    frame_state_t;
    typedef enum logic {DIV_IDLE, DIV_BUSY} div_state_t;

    typedef struct packed {
        logic          found;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] count;
        logic [XW-1:0] xmin;
        logic [XW-1:0] xmax;
        logic [YW-1:0] ymin;
        logic [YW-1:0] ymax;
    } result_t;

endpackage

// File: rtl/target_locator_if.sv
// -----------------------------------------------------------------------------
// target_locator_if
// Bundles the pixel stream from the colour classifier and the result port to
// the steering controller.
//   pix_valid/pix_sop/pix_eop/pix_hit : pixel stream (master -> slave)
//   out_ready                         : result accept (master -> slave)
//   out_valid/out_found/out_x/out_y/out_count/out_x*/out_y*/overrun
//                                     : result and status (slave -> master)
// The slave modport is the locator; the master modport is its environment.
// -----------------------------------------------------------------------------
interface target_locator_if;
    import target_pkg::*;

    logic          pix_valid;
    logic          pix_sop;
    logic          pix_eop;
    logic          pix_hit;
    logic          out_ready;
    logic          out_valid;
    logic          out_found;
    logic [XW-1:0] out_x;
    logic [YW-1:0] out_y;
    logic [CW-1:0] out_count;
    logic [XW-1:0] out_xmin;
    logic [XW-1:0] out_xmax;
    logic [YW-1:0] out_ymin;
    logic [YW-1:0] out_ymax;
    logic          overrun;

    modport master (
        output pix_valid, pix_sop, pix_eop, pix_hit, out_ready,
        input  out_valid, out_found, out_x, out_y, out_count,
               out_xmin, out_xmax, out_ymin, out_ymax, overrun
    );

    modport slave (
        input  pix_valid, pix_sop, pix_eop, pix_hit, out_ready,
        output out_valid, out_found, out_x, out_y, out_count,
               out_xmin, out_xmax, out_ymin, out_ymax, overrun
    );

endinterface

// File: rtl/target_locator_serial_divider.sv
// -----------------------------------------------------------------------------
// serial_divider
// Restoring divider, one quotient bit per clock, W cycles per division.
//   clk, rst     : clock, asynchronous active-high reset
//   i_start      : load dividend/divisor and begin
//   i_dividend   : W-bit dividend
//   i_divisor    : W-bit divisor (0 yields all-ones; caller masks that case)
//   o_busy       : iterations in progress
//   o_done       : one-cycle pulse, quotient valid from this cycle on
//   o_quot       : low QW bits of the truncated quotient
// -----------------------------------------------------------------------------
module serial_divider #(
    parameter int W  = 8,
    parameter int QW = W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [W-1:0]  i_dividend,
    input  logic [W-1:0]  i_divisor,
    output logic          o_busy,
    output logic          o_done,
    output logic [QW-1:0] o_quot
);
    localparam int CNTW = $clog2(W + 1);

    logic [W-1:0]    r_rem;
    logic [W-1:0]    r_quot;
    logic [W-1:0]    r_div;
    logic [CNTW-1:0] r_cnt;
    logic            r_busy;
    logic            r_done;

    // The dividend sits in r_quot and shifts out MSB-first into the remainder
    // while quotient bits shift in from the right.
    logic [W:0]   w_rem_sh;
    logic [W-1:0] w_diff;
    logic         w_ge;

    assign w_rem_sh = {r_rem, r_quot[W-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_div});
    // Only used when w_ge, where the true difference always fits in W bits.
    assign w_diff   = w_rem_sh[W-1:0] - r_div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_rem  <= '0;
                r_quot <= i_dividend;
                r_div  <= i_divisor;
                r_cnt  <= CNTW'(W);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem  <= w_ge ? w_diff : w_rem_sh[W-1:0];
                r_quot <= {r_quot[W-2:0], w_ge};
                r_cnt  <= r_cnt - CNTW'(1);
                if (r_cnt == CNTW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_quot = r_quot[QW-1:0];

endmodule

// File: rtl/target_locator.sv
// -----------------------------------------------------------------------------
// target_locator
// Raster-counts pixel positions of the colour-match stream, accumulates hit
// coordinates per frame and, at end of frame, divides the sums to report the
// target centroid, hit count and optional bounding box on a valid/ready port.
//   clk, rst : pixel clock, asynchronous active-high reset
//   bus      : target_locator_if.slave (pixel stream in, result port out,
//              sticky overrun status)
// Parameters: IMG_W, IMG_H (line length / frame height for position counting),
//   MIN_PIXELS (hit count needed for out_found). Port widths come from
//   target_pkg and are sized for the default geometry.
// Build option: define TARGET_LOCATOR_BBOX_EN to build the min/max trackers;
//   otherwise out_xmin/out_xmax/out_ymin/out_ymax are tied to 0.
// Latency: eop pixel in cycle N -> out_valid in cycle N+DIVW+2.
// -----------------------------------------------------------------------------
module target_locator
    import target_pkg::*;
#(
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int MIN_PIXELS = MIN_PIXELS_DEF
) (
    input  logic clk,
    input  logic rst,
    target_locator_if.slave bus
);
    localparam int            SYW     = CW + YW;
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
    localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIXELS);

    frame_state_t    r_frame_st;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic [CW-1:0]   r_cnt;
    logic [DIVW-1:0] r_sum_x;
    logic [SYW-1:0]  r_sum_y;

    // A pixel counts if it opens a frame or arrives inside one. An sop pixel
    // sees cleared accumulators and position 0,0, so a restart mid-frame
    // silently discards the partial sums.
    logic            w_take;
    logic            w_hit;
    logic            w_close;
    logic [XW-1:0]   w_px;
    logic [YW-1:0]   w_py;
    logic [XW-1:0]   w_x_adv;
    logic [YW-1:0]   w_y_adv;
    logic [CW-1:0]   w_cnt_base;
    logic [CW-1:0]   w_cnt_nxt;
    logic [DIVW-1:0] w_sum_x_nxt;
    logic [SYW-1:0]  w_sum_y_nxt;
    logic [XW-1:0]   w_xmin_nxt;
    logic [XW-1:0]   w_xmax_nxt;
    logic [YW-1:0]   w_ymin_nxt;
    logic [YW-1:0]   w_ymax_nxt;

    assign w_take     = bus.pix_valid && (bus.pix_sop || r_frame_st == ACCUM);
    assign w_hit      = w_take && bus.pix_hit;
    assign w_close    = w_take && bus.pix_eop;
    assign w_px       = bus.pix_sop ? '0 : r_x;
    assign w_py       = bus.pix_sop ? '0 : r_y;
    assign w_cnt_base = bus.pix_sop ? '0 : r_cnt;
    assign w_cnt_nxt  = w_cnt_base + CW'(w_hit);
    assign w_sum_x_nxt = (bus.pix_sop ? '0 : r_sum_x) + (w_hit ? DIVW'(w_px) : '0);
    assign w_sum_y_nxt = (bus.pix_sop ? '0 : r_sum_y) + (w_hit ? SYW'(w_py) : '0);

    // Column wraps at the end of a line; row sticks at the last line.
    assign w_x_adv = (w_px == X_LAST) ? '0 : w_px + XW'(1);
    assign w_y_adv = (w_px == X_LAST && w_py != Y_LAST) ? w_py + YW'(1) : w_py;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_st <= WAIT_SOP;
            r_x        <= '0;
            r_y        <= '0;
            r_cnt      <= '0;
            r_sum_x    <= '0;
            r_sum_y    <= '0;
        end else if (w_take) begin
            r_frame_st <= bus.pix_eop ? WAIT_SOP : ACCUM;
            r_x        <= w_x_adv;
            r_y        <= w_y_adv;
            r_cnt      <= w_cnt_nxt;
            r_sum_x    <= w_sum_x_nxt;
            r_sum_y    <= w_sum_y_nxt;
        end
    end

`ifdef TARGET_LOCATOR_BBOX_EN
    logic [XW-1:0] r_xmin;
    logic [XW-1:0] r_xmax;
    logic [YW-1:0] r_ymin;
    logic [YW-1:0] r_ymax;
    logic          w_first;

    // The first hit of a frame seeds all four bounds; an empty frame keeps
    // the cleared zeros.
    assign w_first = (w_cnt_base == '0);

    always_comb begin
        w_xmin_nxt = bus.pix_sop ? '0 : r_xmin;
        w_xmax_nxt = bus.pix_sop ? '0 : r_xmax;
        w_ymin_nxt = bus.pix_sop ? '0 : r_ymin;
        w_ymax_nxt = bus.pix_sop ? '0 : r_ymax;
        if (w_hit) begin
            if (w_first || w_px < w_xmin_nxt) w_xmin_nxt = w_px;
            if (w_first || w_px > w_xmax_nxt) w_xmax_nxt = w_px;
            if (w_first || w_py < w_ymin_nxt) w_ymin_nxt = w_py;
            if (w_first || w_py > w_ymax_nxt) w_ymax_nxt = w_py;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xmin <= '0;
            r_xmax <= '0;
            r_ymin <= '0;
            r_ymax <= '0;
        end else if (w_take) begin
            r_xmin <= w_xmin_nxt;
            r_xmax <= w_xmax_nxt;
            r_ymin <= w_ymin_nxt;
            r_ymax <= w_ymax_nxt;
        end
    end
`else
    assign w_xmin_nxt = '0;
    assign w_xmax_nxt = '0;
    assign w_ymin_nxt = '0;
    assign w_ymax_nxt = '0;
`endif

    // ---------------- divide stage ----------------
    div_state_t    r_div_st;
    result_t       r_snap;
    result_t       r_res;
    result_t       w_res_new;
    logic          r_out_valid;
    logic          r_overrun;
    logic          w_busy_x;
    logic          w_busy_y;
    logic          w_done_x;
    logic          w_done_y;
    logic          w_done;
    logic          w_stage_busy;
    logic          w_start;
    logic [XW-1:0] w_qx;
    logic [YW-1:0] w_qy;

    // The stage stays busy through the done cycle until the result is loaded.
    assign w_stage_busy = (r_div_st == DIV_BUSY) || w_busy_x || w_busy_y;
    assign w_start      = w_close && !w_stage_busy;
    assign w_done       = w_done_x && w_done_y;

    // Both dividers run at sum_x width so they finish on the same cycle.
    serial_divider #(.W(DIVW), .QW(XW)) u_div_x (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_dividend (w_sum_x_nxt),
        .i_divisor  (DIVW'(w_cnt_nxt)),
        .o_busy     (w_busy_x),
        .o_done     (w_done_x),
        .o_quot     (w_qx)
    );

    serial_divider #(.W(DIVW), .QW(YW)) u_div_y (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_dividend (DIVW'(w_sum_y_nxt)),
        .i_divisor  (DIVW'(w_cnt_nxt)),
        .o_busy     (w_busy_y),
        .o_done     (w_done_y),
        .o_quot     (w_qy)
    );

    // A zero count means the dividers divided by zero; force the centroid to 0.
    always_comb begin
        w_res_new       = r_snap;
        w_res_new.found = (r_snap.count >= MIN_CNT);
        w_res_new.x     = (r_snap.count == '0) ? '0 : w_qx;
        w_res_new.y     = (r_snap.count == '0) ? '0 : w_qy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_st    <= DIV_IDLE;
            r_snap      <= '0;
            r_res       <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_close && w_stage_busy) begin
                r_overrun <= 1'b1;
            end
            case (r_div_st)
                DIV_IDLE: begin
                    if (w_start) begin
                        r_snap.found <= 1'b0;
                        r_snap.x     <= '0;
                        r_snap.y     <= '0;
                        r_snap.count <= w_cnt_nxt;
                        r_snap.xmin  <= w_xmin_nxt;
                        r_snap.xmax  <= w_xmax_nxt;
                        r_snap.ymin  <= w_ymin_nxt;
                        r_snap.ymax  <= w_ymax_nxt;
                        r_div_st     <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    if (w_done) begin
                        r_div_st <= DIV_IDLE;
                    end
                end
                default: r_div_st <= DIV_IDLE;
            endcase
            // A new result replaces whatever is held; losing an unaccepted
            // one is recorded as overrun.
            if (r_div_st == DIV_BUSY && w_done) begin
                r_res       <= w_res_new;
                r_out_valid <= 1'b1;
                if (r_out_valid && !bus.out_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_found = r_res.found;
    assign bus.out_x     = r_res.x;
    assign bus.out_y     = r_res.y;
    assign bus.out_count = r_res.count;
    assign bus.out_xmin  = r_res.xmin;
    assign bus.out_xmax  = r_res.xmax;
    assign bus.out_ymin  = r_res.ymin;
    assign bus.out_ymax  = r_res.ymax;
    assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_target_locator.sv
// -----------------------------------------------------------------------------
// tb_target_locator
// Self-checking bench for target_locator: a table of rectangle frames with
// hand-computed results, randomized frames against a reference model, and
// hand-written sequences for restart, reset, overwrite and drop cases.
// Honours TARGET_LOCATOR_BBOX_EN the same way as the design.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_target_locator;
    import target_pkg::*;

    localparam int IMG_W      = IMG_W_DEF;
    localparam int IMG_H      = IMG_H_DEF;
    localparam int MIN_PIXELS = MIN_PIXELS_DEF;
    localparam int LAT        = DIVW + 1;   // clock edges from eop edge to out_valid

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    target_locator_if bus();

    target_locator #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .MIN_PIXELS (MIN_PIXELS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    bit hq[$];           // hit flag of each pixel of the frame to send

    typedef struct {
        string name;
        int    len, x0, x1, y0, y1;
        bit    found;
        int    count, x, y, xmin, xmax, ymin, ymax;
    } vec_t;
    vec_t tbl[6];

    function automatic result_t get_out();
        result_t r;
        r.found = bus.out_found;
        r.x     = bus.out_x;
        r.y     = bus.out_y;
        r.count = bus.out_count;
        r.xmin  = bus.out_xmin;
        r.xmax  = bus.out_xmax;
        r.ymin  = bus.out_ymin;
        r.ymax  = bus.out_ymax;
        return r;
    endfunction

    task automatic check_res(input string name, input result_t exp);
        result_t act;
        act = get_out();
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got found=%0d x=%0d y=%0d count=%0d bbox=%0d/%0d/%0d/%0d, expected found=%0d x=%0d y=%0d count=%0d bbox=%0d/%0d/%0d/%0d",
                      name, act.found, act.x, act.y, act.count, act.xmin, act.xmax, act.ymin, act.ymax,
                      exp.found, exp.x, exp.y, exp.count, exp.xmin, exp.xmax, exp.ymin, exp.ymax);
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: position from the pixel index, then plain sums and division.
    function automatic result_t model();
        result_t r;
        longint cnt = 0, sx = 0, sy = 0;
        int xmn = 0, xmx = 0, ymn = 0, ymx = 0;
        for (int i = 0; i < hq.size(); i++) begin
            int x, y;
            x = i % IMG_W;
            y = i / IMG_W;
            if (y > IMG_H - 1) y = IMG_H - 1;
            if (hq[i]) begin
                if (cnt == 0) begin
                    xmn = x; xmx = x; ymn = y; ymx = y;
                end else begin
                    if (x < xmn) xmn = x;
                    if (x > xmx) xmx = x;
                    if (y < ymn) ymn = y;
                    if (y > ymx) ymx = y;
                end
                cnt++;
                sx += x;
                sy += y;
            end
        end
        r.found = (cnt >= MIN_PIXELS);
        r.count = CW'(cnt);
        r.x     = (cnt == 0) ? '0 : XW'(sx / cnt);
        r.y     = (cnt == 0) ? '0 : YW'(sy / cnt);
`ifdef TARGET_LOCATOR_BBOX_EN
        r.xmin = XW'(xmn); r.xmax = XW'(xmx); r.ymin = YW'(ymn); r.ymax = YW'(ymx);
`else
        r.xmin = '0; r.xmax = '0; r.ymin = '0; r.ymax = '0;
`endif
        return r;
    endfunction

    function automatic result_t exp_of(input vec_t v);
        result_t r;
        r.found = v.found;
        r.count = CW'(v.count);
        r.x     = XW'(v.x);
        r.y     = YW'(v.y);
`ifdef TARGET_LOCATOR_BBOX_EN
        r.xmin = XW'(v.xmin); r.xmax = XW'(v.xmax); r.ymin = YW'(v.ymin); r.ymax = YW'(v.ymax);
`else
        r.xmin = '0; r.xmax = '0; r.ymin = '0; r.ymax = '0;
`endif
        return r;
    endfunction

    task automatic build_rect(input int len, input int x0, input int x1, input int y0, input int y1);
        hq.delete();
        for (int i = 0; i < len; i++) begin
            int x, y;
            x = i % IMG_W;
            y = i / IMG_W;
            hq.push_back(x >= x0 && x <= x1 && y >= y0 && y <= y1);
        end
    endtask

    task automatic build_random(input int len, input int pct);
        hq.delete();
        for (int i = 0; i < len; i++) hq.push_back($urandom_range(0, 99) < pct);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        bus.pix_valid = 1'b0;
        bus.pix_sop   = 1'($urandom_range(0, 1));
        bus.pix_eop   = 1'($urandom_range(0, 1));
        bus.pix_hit   = 1'($urandom_range(0, 1));
        tick();
    endtask

    // Valid hits outside any frame must be ignored.
    task automatic stray_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            bus.pix_valid = 1'b1;
            bus.pix_sop   = 1'b0;
            bus.pix_eop   = 1'($urandom_range(0, 1));
            bus.pix_hit   = 1'b1;
            tick();
        end
        bus.pix_valid = 1'b0;
        bus.pix_eop   = 1'b0;
    endtask

    task automatic send_frame(input bit with_eop, input bit gaps);
        for (int i = 0; i < hq.size(); i++) begin
            if (gaps) while ($urandom_range(0, 4) == 0) idle_cycle();
            bus.pix_valid = 1'b1;
            bus.pix_sop   = (i == 0);
            bus.pix_eop   = with_eop && (i == hq.size() - 1);
            bus.pix_hit   = hq[i];
            tick();
        end
        bus.pix_valid = 1'b0;
        bus.pix_sop   = 1'b0;
        bus.pix_eop   = 1'b0;
        bus.pix_hit   = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic wait_check(input string name, input result_t exp);
        int lat;
        wait_result(lat);
        check_val({name, " latency"}, lat, LAT);
        check_res(name, exp);
        repeat (3) tick();
        check_res({name, " held"}, exp);
        accept();
        check_val({name, " valid drop"}, bus.out_valid, 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        result_t ea, eb;
        int lat;

        tbl[0] = '{"square",     70*IMG_W, 100, 119, 50, 69, 1'b1, 400, 109, 59, 100, 119, 50, 69};
        tbl[1] = '{"ten hits",   3*IMG_W,  5,   14,  2,  2,  1'b0, 10,  9,   2,  5,   14,  2,  2};
        tbl[2] = '{"all miss",   2*IMG_W,  1,   0,   0,  0,  1'b0, 0,   0,   0,  0,   0,   0,  0};
        tbl[3] = '{"full line",  2*IMG_W,  0,   319, 0,  0,  1'b1, 320, 159, 0,  0,   319, 0,  0};
        tbl[4] = '{"line wrap",  4*IMG_W,  318, 319, 0,  3,  1'b0, 8,   318, 1,  318, 319, 0,  3};
        tbl[5] = '{"sop+eop",    1,        0,   0,   0,  0,  1'b0, 1,   0,   0,  0,   0,   0,  0};

        bus.pix_valid = 1'b0;
        bus.pix_sop   = 1'b0;
        bus.pix_eop   = 1'b0;
        bus.pix_hit   = 1'b0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check_res("reset outputs", '0);
        check_val("reset valid", bus.out_valid, 0);
        check_val("reset overrun", bus.overrun, 0);
        rst = 1'b0;
        tick();

        foreach (tbl[k]) begin
            build_rect(tbl[k].len, tbl[k].x0, tbl[k].x1, tbl[k].y0, tbl[k].y1);
            stray_pixels(2);
            send_frame(1'b1, 1'b0);
            wait_check(tbl[k].name, exp_of(tbl[k]));
        end
        check_val("no overrun after table", bus.overrun, 0);

        for (int r = 0; r < 8; r++) begin
            int pcts[3] = '{5, 50, 95};
            build_random($urandom_range(1, 900), pcts[$urandom_range(0, 2)]);
            ea = model();
            stray_pixels($urandom_range(0, 3));
            send_frame(1'b1, 1'b1);
            wait_check($sformatf("random %0d", r), ea);
        end

        // Restart: unterminated frame full of hits, then a fresh sop frame.
        build_random(300, 100);
        send_frame(1'b0, 1'b0);
        build_rect(400, 10, 29, 0, 0);
        ea = model();
        send_frame(1'b1, 1'b0);
        wait_check("sop restart", ea);

        // Reset while a result is held and the next frame is dividing.
        build_random(100, 100);
        send_frame(1'b1, 1'b0);
        wait_result(lat);
        build_random(200, 50);
        send_frame(1'b1, 1'b0);
        repeat (10) tick();
        pulse_reset();
        check_res("reset mid-divide outputs", '0);
        check_val("reset mid-divide valid", bus.out_valid, 0);
        tick();
        rst = 1'b0;
        repeat (LAT + 10) tick();
        check_val("no result after abort", bus.out_valid, 0);

        // Reset mid-frame, then a complete frame.
        build_random(250, 100);
        send_frame(1'b0, 1'b0);
        pulse_reset();
        tick();
        rst = 1'b0;
        tick();
        build_rect(3*IMG_W, 40, 60, 1, 2);
        ea = model();
        send_frame(1'b1, 1'b0);
        wait_check("after reset mid-frame", ea);

        // Two results with out_ready low: second overwrites first.
        build_rect(IMG_W, 0, 9, 0, 0);
        ea = model();
        send_frame(1'b1, 1'b0);
        wait_result(lat);
        check_res("overwrite first", ea);
        check_val("overwrite no overrun yet", bus.overrun, 0);
        build_rect(2*IMG_W, 0, 319, 1, 1);
        eb = model();
        send_frame(1'b1, 1'b0);
        repeat (LAT) tick();
        check_val("overwrite valid", bus.out_valid, 1);
        check_res("overwrite second", eb);
        check_val("overwrite overrun", bus.overrun, 1);
        accept();
        check_val("overwrite valid drop", bus.out_valid, 0);
        repeat (5) tick();
        check_val("overrun sticky", bus.overrun, 1);

        // Frame ending while the divider is busy is dropped.
        pulse_reset();
        tick();
        rst = 1'b0;
        tick();
        check_val("overrun cleared by reset", bus.overrun, 0);
        build_random(1, 100);
        ea = model();
        send_frame(1'b1, 1'b0);
        build_random(5, 100);
        send_frame(1'b1, 1'b0);
        wait_result(lat);
        check_res("drop keeps first", ea);
        check_val("drop overrun", bus.overrun, 1);
        accept();
        repeat (LAT + 10) tick();
        check_val("dropped frame gives no result", bus.out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
